// File: rtl/alu_logic_pkg.sv
// Shared definitions for the bitwise logic unit: op encodings and default width.
package alu_logic_pkg;

  typedef logic [1:0] op_sel_t;

  localparam op_sel_t OP_AND  = 2'b00;
  localparam op_sel_t OP_NAND = 2'b01;
  localparam op_sel_t OP_NOR  = 2'b10;
  localparam op_sel_t OP_RSVD = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/and_nand_nor_unit_if.sv
// Operand/result bundle for and_nand_nor_unit; master drives operands, slave returns results.
interface and_nand_nor_unit_if
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  op_sel_t          op_sel;
  logic             out_valid;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] nand_out;
  logic [WIDTH-1:0] nor_out;
  logic [WIDTH-1:0] result;
  logic             op_err;

  modport master (
    output in_valid, in1, in2, op_sel,
    input  out_valid, and_out, nand_out, nor_out, result, op_err
  );

  modport slave (
    input  in_valid, in1, in2, op_sel,
    output out_valid, and_out, nand_out, nor_out, result, op_err
  );

endinterface

// File: rtl/bit_gate_comb.sv
// Purely combinational per-bit AND/NAND/NOR of two operands.
module bit_gate_comb #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] nand_o,
  output logic [WIDTH-1:0] nor_o
);

  assign and_o  = a & b;
  assign nand_o = ~(a & b);
  assign nor_o  = ~(a | b);

endmodule

// File: rtl/and_nand_nor_unit.sv
// Registered bitwise logic unit: AND/NAND/NOR in parallel plus an op-selected result,
// one cycle of latency, holding its outputs while idle.
module and_nand_nor_unit
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  and_nand_nor_unit_if.slave bus
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_result;
  logic             w_op_err;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_and;
  logic [WIDTH-1:0] r_nand;
  logic [WIDTH-1:0] r_nor;
  logic [WIDTH-1:0] r_result;
  logic             r_op_err;

  bit_gate_comb #(
    .WIDTH (WIDTH)
  ) u_gates (
    .a      (bus.in1),
    .b      (bus.in2),
    .and_o  (w_and),
    .nand_o (w_nand),
    .nor_o  (w_nor)
  );

  // Result mux and illegal-op decode; the reserved op yields zeros and flags an error.
  always_comb begin
    w_result = '0;
    w_op_err = 1'b0;
    case (bus.op_sel)
      OP_AND:  w_result = w_and;
      OP_NAND: w_result = w_nand;
      OP_NOR:  w_result = w_nor;
      default: w_op_err = 1'b1;
    endcase
  end

  // Output registers: reset clears everything (gate identities included), idle holds data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_and       <= '0;
      r_nand      <= '0;
      r_nor       <= '0;
      r_result    <= '0;
      r_op_err    <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_and    <= w_and;
        r_nand   <= w_nand;
        r_nor    <= w_nor;
        r_result <= w_result;
        r_op_err <= w_op_err;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.and_out   = r_and;
  assign bus.nand_out  = r_nand;
  assign bus.nor_out   = r_nor;
  assign bus.result    = r_result;
  assign bus.op_err    = r_op_err;

endmodule

// File: tb/tb_and_nand_nor_unit.sv
// Directed bench for and_nand_nor_unit: a 1-bit instance for the truth table and an
// 8-bit instance for op select, illegal op, idle hold and mid-stream reset.
module tb_and_nand_nor_unit;
  import alu_logic_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  and_nand_nor_unit_if #(.WIDTH(1)) if1 ();
  and_nand_nor_unit_if #(.WIDTH(8)) if8 ();

  and_nand_nor_unit #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  and_nand_nor_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [7:0] a, input logic [7:0] na,
                      input logic [7:0] no, input logic [7:0] r, input logic e);
    chk({tag, ".out_valid"}, 64'(if8.out_valid), 64'(v));
    chk({tag, ".and_out"},   64'(if8.and_out),   64'(a));
    chk({tag, ".nand_out"},  64'(if8.nand_out),  64'(na));
    chk({tag, ".nor_out"},   64'(if8.nor_out),   64'(no));
    chk({tag, ".result"},    64'(if8.result),    64'(r));
    chk({tag, ".op_err"},    64'(if8.op_err),    64'(e));
  endtask

  task automatic chk1(input string tag, input logic v, input logic a, input logic na,
                      input logic no, input logic r, input logic e);
    chk({tag, ".out_valid"}, 64'(if1.out_valid), 64'(v));
    chk({tag, ".and_out"},   64'(if1.and_out),   64'(a));
    chk({tag, ".nand_out"},  64'(if1.nand_out),  64'(na));
    chk({tag, ".nor_out"},   64'(if1.nor_out),   64'(no));
    chk({tag, ".result"},    64'(if1.result),    64'(r));
    chk({tag, ".op_err"},    64'(if1.op_err),    64'(e));
  endtask

  initial begin
    logic [3:0] tt_a;
    logic [3:0] tt_b;
    logic [3:0] tt_and;
    logic [3:0] tt_nand;
    logic [3:0] tt_nor;
    n_pass  = 0;
    n_total = 0;

    // Reset held with valid all-ones inputs: nothing may leak through.
    rst_n = 1'b0;
    if1.in_valid = 1'b1; if1.in1 = 1'b1;  if1.in2 = 1'b1;  if1.op_sel = OP_AND;
    if8.in_valid = 1'b1; if8.in1 = 8'hFF; if8.in2 = 8'hFF; if8.op_sel = OP_NAND;
    step();
    step();
    chk1("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk8("rst8", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Release with no valid input: still idle.
    rst_n = 1'b1;
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    step();
    chk1("post_rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1-bit truth table, vectors (a,b) = 00,01,10,11.
    tt_a    = 4'b1100;
    tt_b    = 4'b1010;
    tt_and  = 4'b1000;
    tt_nand = 4'b0111;
    tt_nor  = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1'b1;
      if1.op_sel   = OP_AND;
      if1.in1      = tt_a[i];
      if1.in2      = tt_b[i];
      step();
      chk1($sformatf("tt%0d", i), 1'b1, tt_and[i], tt_nand[i], tt_nor[i], tt_and[i], 1'b0);
    end
    if1.in_valid = 1'b0;
    step();
    chk("tt_idle.out_valid", 64'(if1.out_valid), 64'd0);
    chk("tt_idle.and_out", 64'(if1.and_out), 64'd1);

    // Back-to-back ops on the 8-bit instance, F0 op CC.
    if8.in_valid = 1'b1; if8.in1 = 8'hF0; if8.in2 = 8'hCC; if8.op_sel = OP_AND;
    step();
    chk8("op_and", 1'b1, 8'hC0, 8'h3F, 8'h03, 8'hC0, 1'b0);
    if8.op_sel = OP_NAND;
    step();
    chk8("op_nand", 1'b1, 8'hC0, 8'h3F, 8'h03, 8'h3F, 1'b0);
    if8.op_sel = OP_NOR;
    step();
    chk8("op_nor", 1'b1, 8'hC0, 8'h3F, 8'h03, 8'h03, 1'b0);

    // Reserved op: gates still update, result zero, error flagged.
    if8.op_sel = OP_RSVD; if8.in1 = 8'hAA; if8.in2 = 8'h0F;
    step();
    chk8("op_rsvd", 1'b1, 8'h0A, 8'hF5, 8'h50, 8'h00, 1'b1);

    // Idle with scrambled inputs: everything holds.
    if8.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if8.in1    = 8'($urandom);
      if8.in2    = 8'($urandom);
      if8.op_sel = 2'($urandom);
      step();
      chk8($sformatf("hold%0d", i), 1'b0, 8'h0A, 8'hF5, 8'h50, 8'h00, 1'b1);
    end

    // Mid-stream reset between two valid transactions.
    if8.in_valid = 1'b1; if8.in1 = 8'hF0; if8.in2 = 8'hCC; if8.op_sel = OP_NAND;
    step();
    chk8("mid_a", 1'b1, 8'hC0, 8'h3F, 8'h03, 8'h3F, 1'b0);
    rst_n = 1'b0;
    if8.in1 = 8'h55; if8.in2 = 8'h33; if8.op_sel = OP_RSVD;
    step();
    chk8("mid_rst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    if8.in1 = 8'hF0; if8.in2 = 8'hCC; if8.op_sel = OP_NOR;
    step();
    chk8("mid_b", 1'b1, 8'hC0, 8'h3F, 8'h03, 8'h03, 1'b0);
    if8.in_valid = 1'b0;
    step();
    chk8("mid_idle", 1'b0, 8'hC0, 8'h3F, 8'h03, 8'h03, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
